// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver FSM states and divider sizing.
// Intended for reuse by both the receiver and the future transmitter.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRKWAIT
    } uart_state_e;

    // Bits needed for a counter running 0..div-1.
    function automatic int tick_cnt_w(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Character output channel of the UART receiver: valid/ready plus per-character status.
// The receiver drives through master; the character consumer uses slave.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_break;
    logic                 rx_overrun;
    logic                 rx_busy;

    modport master (
        output rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_overrun, rx_busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_break, rx_overrun, rx_busy,
        output rx_ready
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle pulse every DIV clocks, phase realigned by restart.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int CW = tick_cnt_w(DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end
endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled 2-of-3 majority bit decision, configurable frame
// format, parity/framing/break/overrun status and a held valid/ready character output.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115_200,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            uart_rx_i,
    uart_rx_param_if.master rx_if
);
    localparam int TICK_DIV = CLK_FREQ_HZ / (BAUD * OVERSAMPLE);
    localparam int OSW      = $clog2(OVERSAMPLE);
    localparam int BW       = $clog2(DATA_BITS);

    if (TICK_DIV < 2) begin : g_div_chk
        $error("uart_rx_param: TICK_DIV must be at least 2");
    end

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic parity_err(input logic [DATA_BITS-1:0] d, input logic p);
        if (PARITY == PAR_ODD)  return ~(^d ^ p);
        if (PARITY == PAR_EVEN) return  (^d ^ p);
        return 1'b0;
    endfunction

    logic                 sync_p0, sync_p1, sync_p2;
    logic                 fall, restart, tick;
    uart_state_e          state;
    logic                 busy;
    logic [OSW-1:0]       os_cnt;
    logic [OSW-1:0]       hi_cnt;
    logic [1:0]           votes;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit, all_zero, stop_err;
    logic                 bit_done, bit_val, zero_n, stop_err_n;
    logic                 done_p1, pe_p1, fe_p1, brk_p1;
    logic [DATA_BITS-1:0] data_p1;
    logic                 vld_q, ovr_q, pe_q, fe_q, brk_q;
    logic [DATA_BITS-1:0] data_q;

    // Stage 0: two-flop synchroniser plus one history flop for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            {sync_p0, sync_p1, sync_p2} <= 3'b111;
        end else begin
            sync_p0 <= uart_rx_i;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign fall    = sync_p2 & ~sync_p1;
    assign restart = (state == ST_IDLE) && fall;

    uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    // The third vote tick is the decision point for every bit of the frame.
    assign bit_done   = tick && (os_cnt == OSW'(OVERSAMPLE / 2 + 1));
    assign bit_val    = maj3(votes[1], votes[0], sync_p1);
    assign zero_n     = all_zero & ~bit_val;
    assign stop_err_n = stop_err | ~bit_val;

    // Stage 1: frame FSM; done_p1 carries the completed character to the output register
    always_ff @(posedge clk) begin
        done_p1 <= 1'b0;
        if (rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            os_cnt   <= '0;
            hi_cnt   <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else begin
            if (tick) begin
                os_cnt <= os_cnt + 1'b1;
                if (os_cnt == OSW'(OVERSAMPLE / 2 - 1) || os_cnt == OSW'(OVERSAMPLE / 2))
                    votes <= {votes[0], sync_p1};
            end
            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        state  <= ST_START;
                        busy   <= 1'b1;
                        os_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        if (bit_val) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state    <= ST_DATA;
                            bit_idx  <= '0;
                            all_zero <= 1'b1;
                            stop_err <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        shift    <= {bit_val, shift[DATA_BITS-1:1]};
                        all_zero <= zero_n;
                        stop_idx <= 1'b0;
                        if (bit_idx == BW'(DATA_BITS - 1))
                            state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (bit_done) begin
                        par_bit  <= bit_val;
                        all_zero <= zero_n;
                        state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        if (stop_idx == 1'(STOP_BITS - 1)) begin
                            done_p1 <= 1'b1;
                            data_p1 <= shift;
                            pe_p1   <= parity_err(shift, par_bit);
                            fe_p1   <= stop_err_n;
                            brk_p1  <= zero_n;
                            if (zero_n) begin
                                state  <= ST_BRKWAIT;
                                hi_cnt <= '0;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            stop_idx <= 1'b1;
                            stop_err <= stop_err_n;
                            all_zero <= zero_n;
                        end
                    end
                end
                ST_BRKWAIT: begin
                    // Leave only after a full bit time of consecutive high ticks.
                    if (tick) begin
                        if (!sync_p1) begin
                            hi_cnt <= '0;
                        end else if (hi_cnt == OSW'(OVERSAMPLE - 1)) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            hi_cnt <= hi_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Stage 2: held output register; a new frame replaces it only if the slot is free or draining
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            ovr_q  <= 1'b0;
            data_q <= '0;
            pe_q   <= 1'b0;
            fe_q   <= 1'b0;
            brk_q  <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (vld_q && rx_if.rx_ready)
                vld_q <= 1'b0;
            if (done_p1) begin
                if (!vld_q || rx_if.rx_ready) begin
                    vld_q  <= 1'b1;
                    data_q <= data_p1;
                    pe_q   <= pe_p1;
                    fe_q   <= fe_p1;
                    brk_q  <= brk_p1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end
        end
    end

    assign rx_if.rx_valid      = vld_q;
    assign rx_if.rx_data       = data_q;
    assign rx_if.rx_parity_err = pe_q;
    assign rx_if.rx_frame_err  = fe_q;
    assign rx_if.rx_break      = brk_q;
    assign rx_if.rx_overrun    = ovr_q;
    assign rx_if.rx_busy       = busy;
endmodule
